// File: rtl/mips_mem_pkg.sv
// Shared access codes, FSM state type and decode helpers for the MEM-stage load/store unit.
package mips_mem_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 32;

    localparam logic [OP_W-1:0] MEM_NONE = 4'd0;
    localparam logic [OP_W-1:0] MEM_LB   = 4'd1;
    localparam logic [OP_W-1:0] MEM_LBU  = 4'd2;
    localparam logic [OP_W-1:0] MEM_LH   = 4'd3;
    localparam logic [OP_W-1:0] MEM_LHU  = 4'd4;
    localparam logic [OP_W-1:0] MEM_LW   = 4'd5;
    localparam logic [OP_W-1:0] MEM_SB   = 4'd9;
    localparam logic [OP_W-1:0] MEM_SH   = 4'd10;
    localparam logic [OP_W-1:0] MEM_SW   = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return op[3];
    endfunction

    // Access size in bytes; 0 marks a code that is treated as NONE.
    function automatic logic [2:0] op_size(input logic [OP_W-1:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 3'd1;
            MEM_LH, MEM_LHU, MEM_SH: return 3'd2;
            MEM_LW, MEM_SW:          return 3'd4;
            default:                 return 3'd0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lane);
        return ((size == 3'd2) && lane[0]) || ((size == 3'd4) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module mem_load_align
    import mips_mem_pkg::*;
(
    input  logic [OP_W-1:0]   i_op,
    input  logic [1:0]        i_lane,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] w_shift;

    assign w_shift = i_rdata >> {i_lane, 3'b000};

    always_comb begin
        o_data = '0;
        case (i_op)
            MEM_LB:  o_data = {{24{w_shift[7]}}, w_shift[7:0]};
            MEM_LBU: o_data = {24'd0, w_shift[7:0]};
            MEM_LH:  o_data = {{16{w_shift[15]}}, w_shift[15:0]};
            MEM_LHU: o_data = {16'd0, w_shift[15:0]};
            MEM_LW:  o_data = w_shift;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_load_store_unit.sv
// MEM-stage data-memory access unit: req/ack transaction, pipeline stall and load extension.
module mem_load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_ena,
    input  logic [3:0]        mem_op_in,
    input  logic [31:0]       mem_addr_in,
    input  logic [31:0]       mem_wdata_in,
    input  logic [4:0]        mem_rt_addr_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [31:0]       dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              stall_o,
    output logic              load_valid,
    output logic [31:0]       load_data,
    output logic [4:0]        load_rt_addr,
    output logic              addr_err,
    output logic              bus_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    mem_state_t  r_state, w_state_nxt;
    logic [3:0]  r_op, w_op_nxt;
    logic [1:0]  r_lane, w_lane_nxt;
    logic [4:0]  r_rt, w_rt_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic        r_dmem_req, w_req_nxt;
    logic        r_dmem_we, w_we_nxt;
    logic [31:0] r_dmem_addr, w_addr_nxt;
    logic [31:0] r_dmem_wdata, w_wdata_nxt;
    logic [3:0]  r_dmem_be, w_be_nxt;
    logic        r_stall, w_stall_nxt;
    logic        r_load_valid, w_lv_nxt;
    logic [31:0] r_load_data, w_ld_nxt;
    logic [4:0]  r_load_rt, w_ldrt_nxt;
    logic        r_addr_err, w_aerr_nxt;
    logic        r_bus_err, w_berr_nxt;

    logic [2:0]  w_size;
    logic [1:0]  w_lane_in;
    logic [3:0]  w_be_in;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_align_data;

    assign w_size    = op_size(mem_op_in);
    assign w_lane_in = mem_addr_in[1:0];

    // Little-endian lane enables and store-data replication for the incoming op.
    always_comb begin
        w_be_in     = 4'b0000;
        w_wdata_rep = '0;
        case (w_size)
            3'd1: begin
                w_be_in     = 4'b0001 << w_lane_in;
                w_wdata_rep = {4{mem_wdata_in[7:0]}};
            end
            3'd2: begin
                w_be_in     = 4'b0011 << w_lane_in;
                w_wdata_rep = {2{mem_wdata_in[15:0]}};
            end
            3'd4: begin
                w_be_in     = 4'b1111;
                w_wdata_rep = mem_wdata_in;
            end
            default: begin
                w_be_in     = 4'b0000;
                w_wdata_rep = '0;
            end
        endcase
    end

    mem_load_align u_align (
        .i_op    (r_op),
        .i_lane  (r_lane),
        .i_rdata (dmem_rdata),
        .o_data  (w_align_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_lane_nxt  = r_lane;
        w_rt_nxt    = r_rt;
        w_cnt_nxt   = '0;
        w_req_nxt   = 1'b0;
        w_stall_nxt = 1'b0;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = '0;
        w_wdata_nxt = '0;
        w_be_nxt    = '0;
        w_lv_nxt    = 1'b0;
        w_ld_nxt    = r_load_data;
        w_ldrt_nxt  = r_load_rt;
        w_aerr_nxt  = 1'b0;
        w_berr_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_ena && (w_size != 3'd0)) begin
                    if (is_misaligned(w_size, w_lane_in)) begin
                        w_aerr_nxt = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_op_nxt    = mem_op_in;
                        w_lane_nxt  = w_lane_in;
                        w_rt_nxt    = mem_rt_addr_in;
                        w_req_nxt   = 1'b1;
                        w_stall_nxt = 1'b1;
                        w_we_nxt    = is_store(mem_op_in);
                        w_addr_nxt  = {mem_addr_in[31:2], 2'b00};
                        w_wdata_nxt = is_store(mem_op_in) ? w_wdata_rep : 32'd0;
                        w_be_nxt    = w_be_in;
                    end
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    w_state_nxt = DONE;
                    if (!is_store(r_op)) begin
                        w_lv_nxt   = 1'b1;
                        w_ld_nxt   = w_align_data;
                        w_ldrt_nxt = r_rt;
                    end
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt = DONE;
                    w_berr_nxt  = 1'b1;
                end else begin
                    // Request held stable from the latched copies until ack or timeout.
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_req_nxt   = 1'b1;
                    w_stall_nxt = 1'b1;
                    w_we_nxt    = r_dmem_we;
                    w_addr_nxt  = r_dmem_addr;
                    w_wdata_nxt = r_dmem_wdata;
                    w_be_nxt    = r_dmem_be;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= '0;
            r_lane       <= '0;
            r_rt         <= '0;
            r_cnt        <= '0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_be    <= '0;
            r_stall      <= 1'b0;
            r_load_valid <= 1'b0;
            r_load_data  <= '0;
            r_load_rt    <= '0;
            r_addr_err   <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_op         <= w_op_nxt;
            r_lane       <= w_lane_nxt;
            r_rt         <= w_rt_nxt;
            r_cnt        <= w_cnt_nxt;
            r_dmem_req   <= w_req_nxt;
            r_dmem_we    <= w_we_nxt;
            r_dmem_addr  <= w_addr_nxt;
            r_dmem_wdata <= w_wdata_nxt;
            r_dmem_be    <= w_be_nxt;
            r_stall      <= w_stall_nxt;
            r_load_valid <= w_lv_nxt;
            r_load_data  <= w_ld_nxt;
            r_load_rt    <= w_ldrt_nxt;
            r_addr_err   <= w_aerr_nxt;
            r_bus_err    <= w_berr_nxt;
        end
    end

    assign dmem_req     = r_dmem_req;
    assign dmem_we      = r_dmem_we;
    assign dmem_addr    = r_dmem_addr;
    assign dmem_wdata   = r_dmem_wdata;
    assign dmem_be      = r_dmem_be;
    assign stall_o      = r_stall;
    assign load_valid   = r_load_valid;
    assign load_data    = r_load_data;
    assign load_rt_addr = r_load_rt;
    assign addr_err     = r_addr_err;
    assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_load_store_unit.sv
// Directed and randomized bench for mem_load_store_unit against a byte-lane memory model.
module tb_mem_load_store_unit;

    localparam int TIMEOUT = 16;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd9;
    localparam logic [3:0] OP_SH  = 4'd10;
    localparam logic [3:0] OP_SW  = 4'd11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_ena = 1'b0;
    logic [3:0]  mem_op_in = '0;
    logic [31:0] mem_addr_in = '0;
    logic [31:0] mem_wdata_in = '0;
    logic [4:0]  mem_rt_addr_in = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        stall_o, load_valid, addr_err, bus_err;
    logic [31:0] load_data;
    logic [4:0]  load_rt_addr;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] model_mem [16];
    logic [3:0]  ops [8];

    always #5 clk = ~clk;

    mem_load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .mem_ena(mem_ena), .mem_op_in(mem_op_in),
        .mem_addr_in(mem_addr_in), .mem_wdata_in(mem_wdata_in), .mem_rt_addr_in(mem_rt_addr_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_o(stall_o),
        .load_valid(load_valid), .load_data(load_data), .load_rt_addr(load_rt_addr),
        .addr_err(addr_err), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int acc_bytes(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    // One MEM-stage instruction; delay = WAIT cycles before ack, negative = never ack.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rt, input int delay);
        int          size, lane, stalls, idx;
        logic        st;
        logic        done;
        logic [3:0]  exp_be;
        logic [31:0] rep, word, shifted, exp_ld;
        size = acc_bytes(op);
        lane = int'(addr[1:0]);
        idx  = int'(addr[5:2]);
        st   = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        @(negedge clk);
        mem_ena = 1'b1; mem_op_in = op; mem_addr_in = addr; mem_wdata_in = wdata; mem_rt_addr_in = rt;
        @(negedge clk);
        if (size == 0) begin
            chk("none_req", 32'(dmem_req), 32'd0);
            chk("none_stall", 32'(stall_o), 32'd0);
            chk("none_aerr", 32'(addr_err), 32'd0);
            mem_ena = 1'b0;
            return;
        end
        if ((size == 2 && (lane % 2) != 0) || (size == 4 && lane != 0)) begin
            chk("aerr_pulse", 32'(addr_err), 32'd1);
            chk("aerr_req", 32'(dmem_req), 32'd0);
            chk("aerr_stall", 32'(stall_o), 32'd0);
            mem_ena = 1'b0;
            @(negedge clk);
            chk("aerr_end", 32'(addr_err), 32'd0);
            chk("aerr_req2", 32'(dmem_req), 32'd0);
            return;
        end
        exp_be = 4'(((1 << size) - 1) << lane);
        rep = (size == 1) ? {4{wdata[7:0]}} : (size == 2) ? {2{wdata[15:0]}} : wdata;
        word = model_mem[idx];
        shifted = word >> (8 * lane);
        if (size == 1) begin
            exp_ld = shifted & 32'hFF;
            if (op == OP_LB && shifted[7]) exp_ld = exp_ld | 32'hFFFFFF00;
        end else if (size == 2) begin
            exp_ld = shifted & 32'hFFFF;
            if (op == OP_LH && shifted[15]) exp_ld = exp_ld | 32'hFFFF0000;
        end else begin
            exp_ld = word;
        end
        stalls = 0;
        done = 1'b0;
        for (int c = 0; c <= TIMEOUT && !done; c++) begin
            chk("wait_req", 32'(dmem_req), 32'd1);
            chk("wait_addr", dmem_addr, {addr[31:2], 2'b00});
            chk("wait_be", 32'(dmem_be), 32'(exp_be));
            chk("wait_we", 32'(dmem_we), 32'(st));
            if (st) chk("wait_wdata", dmem_wdata, rep);
            chk("wait_lv", 32'(load_valid), 32'd0);
            if (stall_o) stalls++;
            if (c == delay) begin
                dmem_ack = 1'b1;
                dmem_rdata = st ? $urandom : word;
            end
            @(negedge clk);
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
            if (c == delay) begin
                done = 1'b1;
                chk("done_lv", 32'(load_valid), 32'(!st));
                if (!st) begin
                    chk("done_data", load_data, exp_ld);
                    chk("done_rt", 32'(load_rt_addr), 32'(rt));
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (exp_be[b]) model_mem[idx][8*b +: 8] = rep[8*b +: 8];
                end
                chk("done_berr", 32'(bus_err), 32'd0);
            end else if (c == TIMEOUT - 1) begin
                done = 1'b1;
                chk("tmo_berr", 32'(bus_err), 32'd1);
                chk("tmo_lv", 32'(load_valid), 32'd0);
            end
        end
        chk("done_req", 32'(dmem_req), 32'd0);
        chk("done_stall", 32'(stall_o), 32'd0);
        chk("stall_cycles", 32'(stalls), (delay < 0) ? 32'(TIMEOUT) : 32'(delay + 1));
        // Instruction is still presented during DONE; it must not be taken again.
        @(negedge clk);
        chk("idle_req", 32'(dmem_req), 32'd0);
        chk("idle_lv", 32'(load_valid), 32'd0);
        chk("idle_berr", 32'(bus_err), 32'd0);
        chk("idle_stall", 32'(stall_o), 32'd0);
        mem_ena = 1'b0;
    endtask

    initial begin
        logic [3:0]  r_op;
        logic [31:0] r_addr;
        int          sz;

        for (int i = 0; i < 16; i++) model_mem[i] = $urandom;
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};

        repeat (2) @(negedge clk);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_lv", 32'(load_valid), 32'd0);
        chk("rst_data", load_data, 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_errs", 32'({addr_err, bus_err}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        model_mem[0] = 32'hDEADBEEF;
        run_op(OP_LW, 32'h0000_0100, 32'd0, 5'd7, 0);
        model_mem[0] = 32'h80112233;
        run_op(OP_LB, 32'h0000_0103, 32'd0, 5'd3, 0);
        run_op(OP_LBU, 32'h0000_0103, 32'd0, 5'd4, 1);
        run_op(OP_SH, 32'h0000_0202, 32'h0000ABCD, 5'd0, 3);
        run_op(OP_LHU, 32'h0000_0202, 32'd0, 5'd0, 0);
        run_op(OP_LW, 32'h0000_0101, 32'd0, 5'd1, 0);
        run_op(OP_LH, 32'h0000_0105, 32'd0, 5'd1, 0);
        run_op(OP_LW, 32'h0000_0104, 32'd0, 5'd9, -1);
        run_op(4'd0, 32'h0000_0100, 32'd0, 5'd1, 0);
        run_op(4'd6, 32'h0000_0100, 32'd0, 5'd1, 0);
        run_op(4'd15, 32'h0000_0100, 32'd0, 5'd1, 0);

        // Valid op without mem_ena, and a stray ack in IDLE, are both ignored.
        @(negedge clk);
        mem_ena = 1'b0; mem_op_in = OP_LW; mem_addr_in = 32'h100; dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("noena_req", 32'(dmem_req), 32'd0);
        chk("stray_ack_lv", 32'(load_valid), 32'd0);

        // Reset in the middle of WAIT abandons the transaction.
        mem_ena = 1'b1; mem_op_in = OP_LW; mem_addr_in = 32'h0000_0108; mem_rt_addr_in = 5'd2;
        @(negedge clk);
        chk("rw_req", 32'(dmem_req), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rw_req0", 32'(dmem_req), 32'd0);
        chk("rw_stall0", 32'(stall_o), 32'd0);
        chk("rw_addr0", dmem_addr, 32'd0);
        chk("rw_outs0", 32'({load_valid, bus_err, addr_err, dmem_we, dmem_be}), 32'd0);
        mem_ena = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (TIMEOUT + 2) begin
            @(negedge clk);
            chk("rw_quiet", 32'({bus_err, load_valid, dmem_req}), 32'd0);
        end
        run_op(OP_LW, 32'h0000_0108, 32'd0, 5'd2, 2);

        for (int i = 0; i < 40; i++) begin
            r_op = ops[$urandom_range(7)];
            r_addr = $urandom;
            sz = acc_bytes(r_op);
            if ($urandom_range(3) != 0) r_addr = r_addr & ~32'(sz - 1);
            run_op(r_op, r_addr, $urandom, 5'($urandom_range(31)), int'($urandom_range(4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
